// File: rtl/wiggle_tlp_completer.sv
// wiggle_tlp_completer: minimal memory-mapped TLP completer.
// Accepts single-DW MWr32/MRd32 TLPs on a 16-bit beat stream, drives four
// 32-bit registers (gpio_a, gpio_b, scratch, read-only ID) and answers reads
// with an 8-beat CplD.
// Optional feature: define WIGGLE_ERR_CNT_EN to build the saturating
// dropped-TLP counter; otherwise err_cnt is tied to zero.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for rx_st
// S_RX       | collecting header/data beats until rx_end
// S_EXEC     | one cycle: apply MWr to the register file, or start MRd reply
// S_CPL_REQ  | tx_req high, waiting for tx_rdy
// S_CPL_SEND | streaming the 8 CplD beats, cnt_q counts down 7..0
module wiggle_tlp_completer #(
  parameter logic [31:0] ID_VALUE = 32'h5749_4747
) (
  input  logic        osc,
  input  logic        perstn,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  input  logic [15:0] cpl_id,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  output logic [31:0] gpio_a,
  output logic [31:0] gpio_b,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_EXEC, S_CPL_REQ, S_CPL_SEND
  } state_t;

  localparam logic [6:0] FMT_MWR = 7'h40;
  localparam logic [6:0] FMT_MRD = 7'h00;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [6:0]  fmt_q, fmt_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] req_id_q, req_id_d;
  logic [7:0]  tag_q, tag_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] gpio_a_q, gpio_a_d;
  logic [31:0] gpio_b_q, gpio_b_d;
  logic [31:0] scratch_q, scratch_d;
  logic [1:0]  err_inc;
  logic        hdr_ok;
  logic        wr_en;
  logic [31:0] be_mask;
  logic [31:0] rdata;
  logic [31:0] cpl_dw1, cpl_dw2;
  logic [15:0] cpl_beat;

  // beat_q holds the index of the beat currently on rx_data, so at rx_end it
  // equals total beats minus one (saturates so over-long TLPs stay invalid)
  assign hdr_ok = (len_q == 10'd1) &&
                  (((fmt_q == FMT_MWR) && (beat_q == 4'd7)) ||
                   ((fmt_q == FMT_MRD) && (beat_q == 4'd5)));

  assign wr_en   = (state_q == S_EXEC) && (fmt_q == FMT_MWR);
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign cpl_dw1 = {cpl_id, 3'b000, 1'b0, 12'd4};
  assign cpl_dw2 = {req_id_q, tag_q, 1'b0, 3'b000, idx_q, 2'b00};

  // FSM next state, header capture, error events and tx outputs
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    fmt_d    = fmt_q;
    len_d    = len_q;
    req_id_d = req_id_q;
    tag_d    = tag_q;
    be_d     = be_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_inc  = 2'd0;
    tx_req   = 1'b0;
    tx_st    = 1'b0;
    tx_end   = 1'b0;
    tx_data  = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (rx_st) begin
          fmt_d  = rx_data[14:8];
          beat_d = 4'd1;
          if (rx_end) err_inc = 2'd1;
          else        state_d = S_RX;
        end
      end
      S_RX: begin
        if (rx_st) begin
          // abort the partial TLP and treat this beat as a fresh b0
          fmt_d  = rx_data[14:8];
          beat_d = 4'd1;
          if (rx_end) begin
            err_inc = 2'd2;
            state_d = S_IDLE;
          end else begin
            err_inc = 2'd1;
          end
        end else begin
          case (beat_q)
            4'd1: len_d = rx_data[9:0];
            4'd2: req_id_d = rx_data;
            4'd3: begin
              tag_d = rx_data[15:8];
              be_d  = rx_data[3:0];
            end
            4'd5: idx_d = rx_data[3:2];
            4'd6: data_d[31:16] = rx_data;
            4'd7: data_d[15:0] = rx_data;
            default: ;
          endcase
          if (beat_q != 4'hF) beat_d = beat_q + 4'd1;
          if (rx_end) begin
            if (hdr_ok) begin
              state_d = S_EXEC;
            end else begin
              state_d = S_IDLE;
              err_inc = 2'd1;
            end
          end
        end
      end
      S_EXEC: begin
        if (rx_st) err_inc = 2'd1;
        state_d = (fmt_q == FMT_MWR) ? S_IDLE : S_CPL_REQ;
      end
      S_CPL_REQ: begin
        tx_req = 1'b1;
        if (rx_st) err_inc = 2'd1;
        if (tx_rdy) begin
          state_d = S_CPL_SEND;
          cnt_d   = 3'd7;
        end
      end
      S_CPL_SEND: begin
        if (rx_st) err_inc = 2'd1;
        tx_st   = (cnt_q == 3'd7);
        tx_end  = (cnt_q == 3'd0);
        tx_data = cpl_beat;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // completion beat select: beat index is 7 - cnt_q, upper half-word first
  always_comb begin
    cpl_beat = 16'h0000;
    case (3'd7 - cnt_q)
      3'd0: cpl_beat = 16'h4A00;
      3'd1: cpl_beat = 16'h0001;
      3'd2: cpl_beat = cpl_dw1[31:16];
      3'd3: cpl_beat = cpl_dw1[15:0];
      3'd4: cpl_beat = cpl_dw2[31:16];
      3'd5: cpl_beat = cpl_dw2[15:0];
      3'd6: cpl_beat = rdata[31:16];
      3'd7: cpl_beat = rdata[15:0];
      default: cpl_beat = 16'h0000;
    endcase
  end

  // register read mux; read live since no write can land while a read is open
  always_comb begin
    rdata = ID_VALUE;
    case (idx_q)
      2'd0: rdata = gpio_a_q;
      2'd1: rdata = gpio_b_q;
      2'd2: rdata = scratch_q;
      default: rdata = ID_VALUE;
    endcase
  end

  // byte-enabled register write in the EXEC cycle; index 3 is read-only
  always_comb begin
    gpio_a_d  = gpio_a_q;
    gpio_b_d  = gpio_b_q;
    scratch_d = scratch_q;
    if (wr_en) begin
      case (idx_q)
        2'd0: gpio_a_d  = (gpio_a_q & ~be_mask) | (data_q & be_mask);
        2'd1: gpio_b_d  = (gpio_b_q & ~be_mask) | (data_q & be_mask);
        2'd2: scratch_d = (scratch_q & ~be_mask) | (data_q & be_mask);
        default: ;
      endcase
    end
  end

  // state, captured header and register file
  always_ff @(posedge osc or negedge perstn) begin
    if (!perstn) begin
      state_q   <= S_IDLE;
      beat_q    <= 4'd0;
      fmt_q     <= 7'd0;
      len_q     <= 10'd0;
      req_id_q  <= 16'd0;
      tag_q     <= 8'd0;
      be_q      <= 4'd0;
      idx_q     <= 2'd0;
      data_q    <= 32'd0;
      cnt_q     <= 3'd0;
      gpio_a_q  <= 32'd0;
      gpio_b_q  <= 32'd0;
      scratch_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      fmt_q     <= fmt_d;
      len_q     <= len_d;
      req_id_q  <= req_id_d;
      tag_q     <= tag_d;
      be_q      <= be_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      gpio_a_q  <= gpio_a_d;
      gpio_b_q  <= gpio_b_d;
      scratch_q <= scratch_d;
    end
  end

  assign gpio_a = gpio_a_q;
  assign gpio_b = gpio_b_q;

`ifdef WIGGLE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum;

  // saturating add of this cycle's dropped-TLP events
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // dropped-TLP counter register
  always_ff @(posedge osc or negedge perstn) begin
    if (!perstn) err_cnt_q <= 8'd0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = ^err_inc;
  assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_wiggle_tlp_completer.sv
// Self-checking bench for wiggle_tlp_completer: directed cases followed by a
// randomized mix of writes, reads and malformed TLPs, checked against a
// register-array reference model. Expected err_cnt follows WIGGLE_ERR_CNT_EN.
module tb_wiggle_tlp_completer;

  logic        osc = 1'b0;
  logic        perstn = 1'b0;
  logic        rx_st = 1'b0;
  logic        rx_end = 1'b0;
  logic [15:0] rx_data = 16'h0;
  logic [15:0] cpl_id = 16'h0200;
  logic        tx_rdy = 1'b0;
  logic        tx_req, tx_st, tx_end;
  logic [15:0] tx_data;
  logic [31:0] gpio_a, gpio_b;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg [0:3];
  int          exp_err = 0;
  logic [15:0] tlp [0:7];

  wiggle_tlp_completer dut (
    .osc(osc), .perstn(perstn), .rx_st(rx_st), .rx_end(rx_end),
    .rx_data(rx_data), .cpl_id(cpl_id), .tx_req(tx_req), .tx_rdy(tx_rdy),
    .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
    .gpio_a(gpio_a), .gpio_b(gpio_b), .err_cnt(err_cnt)
  );

  always #5 osc = ~osc;

  initial begin
    #2000000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic note_err();
`ifdef WIGGLE_ERR_CNT_EN
    if (exp_err < 255) exp_err++;
`endif
  endtask

  task automatic model_reset();
    mreg[0] = 32'd0;
    mreg[1] = 32'd0;
    mreg[2] = 32'd0;
    mreg[3] = 32'h5749_4747;
    exp_err = 0;
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [3:0] be, input logic [31:0] data);
    if (idx != 2'd3)
      for (int i = 0; i < 4; i++)
        if (be[i]) mreg[idx][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_gpio_a"}, gpio_a, mreg[0]);
    check({tag, "_gpio_b"}, gpio_b, mreg[1]);
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic drive(input logic s, input logic e, input logic [15:0] d);
    @(negedge osc);
    rx_st = s;
    rx_end = e;
    rx_data = d;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) drive(i == 0, i == n - 1, tlp[i]);
    drive(1'b0, 1'b0, 16'h0);
  endtask

  task automatic build(input logic [6:0] fmt, input logic [9:0] len, input logic [15:0] req,
                       input logic [7:0] tag, input logic [3:0] be, input logic [1:0] idx,
                       input logic [31:0] data);
    logic [15:0] r;
    r = 16'($urandom); tlp[0] = {r[15], fmt, r[7:0]};
    r = 16'($urandom); tlp[1] = {r[15:10], len};
    tlp[2] = req;
    r = 16'($urandom); tlp[3] = {tag, r[7:4], be};
    tlp[4] = 16'($urandom);
    r = 16'($urandom); tlp[5] = {r[15:4], idx, r[1:0]};
    tlp[6] = data[31:16];
    tlp[7] = data[15:0];
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [3:0] be, input logic [31:0] data);
    build(7'h40, 10'd1, 16'($urandom), 8'($urandom), be, idx, data);
    send(8);
    check("wr_pre_gpio_a", gpio_a, mreg[0]);
    check("wr_pre_gpio_b", gpio_b, mreg[1]);
    model_write(idx, be, data);
    @(negedge osc);
    check_regs("wr");
    check("wr_no_tx_req", 32'(tx_req), 32'd0);
  endtask

  task automatic do_bad(input int kind);
    case (kind)
      0: begin build(7'h40, 10'd2, 16'($urandom), 8'($urandom), 4'hF, 2'($urandom), $urandom); send(8); end
      1: begin build(7'h20, 10'd1, 16'($urandom), 8'($urandom), 4'hF, 2'($urandom), $urandom); send(8); end
      default: begin build(7'h40, 10'd1, 16'($urandom), 8'($urandom), 4'hF, 2'($urandom), $urandom); send(6); end
    endcase
    note_err();
    repeat (2) @(negedge osc);
    check("bad_no_tx_req", 32'(tx_req), 32'd0);
    check_regs("bad");
  endtask

  task automatic do_read(input logic [1:0] idx, input logic [7:0] tag, input logic [15:0] req,
                         input int delay, input bit inject, input int rst_at);
    logic [31:0] dw [0:3];
    logic [15:0] want;
    int k;
    build(7'h00, 10'd1, req, tag, 4'($urandom), idx, $urandom);
    send(6);
    k = 0;
    while (!tx_req && k < 20) begin
      @(negedge osc);
      k++;
    end
    check("rd_tx_req", 32'(tx_req), 32'd1);
    if (!tx_req) return;
    if (inject) begin
      build(7'h40, 10'd1, 16'($urandom), 8'($urandom), 4'hF, 2'($urandom), $urandom);
      send(8);
      note_err();
      check("busy_tx_req", 32'(tx_req), 32'd1);
      check_regs("busy");
    end
    repeat (delay) @(negedge osc);
    check("rd_hold", {30'd0, tx_req, tx_st}, 32'd2);
    dw[0] = 32'h4A00_0001;
    dw[1] = {cpl_id, 16'd4};
    dw[2] = {req, tag, 8'(idx * 4)};
    dw[3] = mreg[idx];
    tx_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge osc);
      tx_rdy = 1'b0;
      want = i[0] ? dw[i/2][15:0] : dw[i/2][31:16];
      check("cpl_data", 32'(tx_data), 32'(want));
      check("cpl_st", 32'(tx_st), 32'(i == 0));
      check("cpl_end", 32'(tx_end), 32'(i == 7));
      if (i == rst_at) begin
        perstn = 1'b0;
        #1;
        model_reset();
        check("rst_tx", {13'd0, tx_req, tx_st, tx_end, tx_data}, 32'd0);
        check_regs("rst");
        @(negedge osc);
        perstn = 1'b1;
        return;
      end
    end
    @(negedge osc);
    check("cpl_done", {13'd0, tx_req, tx_st, tx_end, tx_data}, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge osc);
    check("reset_tx", {13'd0, tx_req, tx_st, tx_end, tx_data}, 32'd0);
    check_regs("reset");
    perstn = 1'b1;
    @(negedge osc);

    do_write(2'd0, 4'hF, 32'hA5A5_0F0F);
    check("req034_gpio_a", gpio_a, 32'hA5A5_0F0F);
    do_write(2'd1, 4'b0101, 32'hFFFF_FFFF);
    check("req035_gpio_b", gpio_b, 32'h00FF_00FF);

    cpl_id = 16'h0200;
    do_read(2'd3, 8'h17, 16'h0100, 3, 1'b0, -1);

    do_write(2'd2, 4'hF, 32'h1234_5678);
    do_read(2'd2, 8'h01, 16'hBEEF, 0, 1'b0, -1);
    do_write(2'd3, 4'hF, 32'hDEAD_BEEF);
    do_read(2'd3, 8'h02, 16'h0001, 1, 1'b0, -1);

    do_read(2'd0, 8'h33, 16'h0042, 2, 1'b1, -1);

    do_bad(0);
    do_bad(1);
    do_bad(2);

    // abort: three beats of a read, then a fresh MWr begins without rx_end
    build(7'h00, 10'd1, 16'h1111, 8'h22, 4'hF, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) drive(i == 0, 1'b0, tlp[i]);
    note_err();
    do_write(2'd2, 4'b1100, 32'hCAFE_F00D);

    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [1:0] ix;
      kind = int'($urandom_range(0, 3));
      ix = 2'($urandom);
      cpl_id = 16'($urandom);
      case (kind)
        0: do_write(ix, 4'($urandom), $urandom);
        1: do_read(ix, 8'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 1'b0, -1);
        2: do_bad(int'($urandom_range(0, 2)));
        default: begin
          do_write(ix, 4'($urandom), $urandom);
          do_read(ix, 8'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 1'b0, -1);
        end
      endcase
    end

    for (int n = 0; n < 260; n++) begin
      drive(1'b1, 1'b0, 16'h4000 | 16'($urandom_range(0, 255)));
      drive(1'b0, 1'b1, 16'($urandom));
      note_err();
    end
    drive(1'b0, 1'b0, 16'h0);
    @(negedge osc);
    check_regs("saturate");

    cpl_id = 16'h0200;
    do_read(2'd1, 8'h44, 16'h0303, 1, 1'b0, 3);
    @(negedge osc);
    check_regs("post_rst");
    do_read(2'd3, 8'h55, 16'h0404, 0, 1'b0, -1);
    do_read(2'd1, 8'h66, 16'h0505, 2, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wiggle_tlp_completer.md
WIGGLE_TLP_COMPLETER -- requirements
Module: wiggle_tlp_completer

Interface
REQ-001 Parameter ID_VALUE, default 32'h5749_4747, read-only value of register 3.
REQ-002 osc  input  1  clock; all logic rising-edge.
REQ-003 perstn  input  1  reset, asynchronous assert, active-low.
REQ-004 rx_st  input  1  first beat of a received TLP.
REQ-005 rx_end  input  1  last beat of a received TLP.
REQ-006 rx_data  input  16  received TLP beat; one beat per cycle from rx_st through rx_end, no backpressure.
REQ-007 cpl_id  input  16  completer ID {bus, dev, func}, used in completion headers.
REQ-008 tx_req  output  1  request to transmit one completion.
REQ-009 tx_rdy  input  1  grant; the stream starts in the cycle after tx_rdy is sampled high.
REQ-010 tx_st / tx_end  output  1 each  first / last completion beat.
REQ-011 tx_data  output  16  completion beat.
REQ-012 gpio_a / gpio_b  output  32 each  contents of register 0 / register 1.
REQ-013 err_cnt  output  8  dropped-TLP counter (see Configuration).

Function
REQ-014 Beat map: b0[14:8] fmt/type, b1[9:0] length, b2 requester ID, b3[15:8] tag, b3[3:0] first BE, b5[3:2] register index, b6..b7 data DW = {b6,b7}.
REQ-015 Accepted TLPs are MWr32 (b0[14:8]=7'h40, 8 beats) and MRd32 (7'h00, 6 beats), both with length 1; all others are dropped without response.
REQ-016 Registers: 0 gpio_a, 1 gpio_b, 2 scratch (all R/W), 3 ID_VALUE (writes ignored).
REQ-017 MWr: register byte i, bits [8i+7:8i], is updated when BE[i]=1, one cycle after the rx_end beat; it is never completed.
REQ-018 MRd: the block returns one CplD carrying the register value, regardless of BE.
REQ-019 FSM states:
- IDLE -> RX on rx_st.
- RX -> EXEC on rx_end with a valid header; RX -> IDLE on rx_end with an invalid header.
- EXEC -> IDLE for MWr; EXEC -> CPL_REQ for MRd.
- CPL_REQ -> CPL_SEND when tx_rdy is sampled high.
- CPL_SEND -> IDLE after 8 beats.
REQ-020 tx_req is high only in CPL_REQ; tx_st is high on beat 0 and tx_end on beat 7; tx_data is 0 outside CPL_SEND.
REQ-021 CplD DW0 = 32'h4A00_0001.
REQ-022 CplD DW1 = {cpl_id, 3'b000, 1'b0, 12'd4}.
REQ-023 CplD DW2 = {req_id, tag, 1'b0, 7'{idx, 2'b00}}.
REQ-024 CplD DW3 = register data.
REQ-025 Each DW is sent as its upper half-word first.
REQ-026 rx_st arriving while the block is in EXEC, CPL_REQ or CPL_SEND drops that TLP and counts it as an error.
REQ-027 rx_st arriving in RX before rx_end aborts the current TLP, counts one error, and restarts RX.
REQ-028 An MWr and MRd in consecutive TLPs to the same register: the read returns the newly written value.

Reset
REQ-029 On perstn low the FSM goes to IDLE; tx_req, tx_st, tx_end, tx_data, gpio_a, gpio_b, scratch and err_cnt all become 0.
REQ-030 Reset during CPL_SEND ends the stream immediately; no tx_end is issued.
REQ-031 Reset release takes effect on the first osc edge with perstn high.

Configuration
REQ-032 With WIGGLE_ERR_CNT_EN defined, err_cnt increments by 1 per dropped TLP (invalid, busy or aborted) and saturates at 8'hFF.
REQ-033 Without WIGGLE_ERR_CNT_EN, err_cnt is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-034 MWr, idx 0, BE 4'hF, data 32'hA5A5_0F0F -> gpio_a = 32'hA5A5_0F0F one cycle after rx_end; no tx_req.
REQ-035 MWr, idx 1, BE 4'b0101, data 32'hFFFF_FFFF, gpio_b initially 0 -> gpio_b = 32'h00FF_00FF.
REQ-036 MRd, idx 3, tag 8'h17, req_id 16'h0100, cpl_id 16'h0200, tx_rdy 3 cycles after tx_req -> tx_data sequence 4A00, 0001, 0200, 0004, 0100, 170C, 5749, 4747, with tx_st on beat 0 and tx_end on beat 7.
REQ-037 MRd followed by an MWr whose rx_st arrives during CPL_REQ -> the MWr is dropped, registers are unchanged, and err_cnt = 1 (0 without the macro).
REQ-038 Length 2, and separately type 7'h20 -> no completion, no register change, err_cnt increments.
REQ-039 perstn pulsed low at CPL_SEND beat 3 -> all outputs 0 immediately and the FSM is IDLE; a following MRd completes normally.
